// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
//   NUM_REQ      number of requesters sharing the RAM ports
//   PTR_W        width of the round-robin priority pointer
//   REQ_DATA_W   address / data width carried in req_t
//   req_t        one requester's transaction {we, addr, wdata}
//   resp_state_t per-port response register state
package ram_arb_pkg;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned PTR_W      = 1;
    localparam int unsigned REQ_DATA_W = 32;

    typedef struct packed {
        logic                  we;
        logic [REQ_DATA_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic {
        RESP_EMPTY = 1'b0,
        RESP_FULL  = 1'b1
    } resp_state_t;

    // Priority passes to the port that was not just served.
    function automatic logic [PTR_W-1:0] other_port(input logic [PTR_W-1:0] served);
        return ~served;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: at most one grant per cycle, ties broken by a
// priority pointer that moves to the other port after every grant.
//   clk, rst_n  clock and synchronous active-low reset (pointer -> port 0)
//   elig[1:0]   per-port eligibility
//   gnt[1:0]    one-hot grant, or zero when nothing is eligible (combinational)
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] elig,
    output logic [1:0] gnt
);

    logic [PTR_W-1:0] ptr;

    // Single eligible port wins outright; a tie goes to the pointed-at port.
    always_comb begin
        gnt = elig;
        if (elig == 2'b11) begin
            gnt = (ptr == PTR_W'(0)) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (|gnt) begin
            ptr <= other_port(PTR_W'(gnt[1]));
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the data RAM's single read and single write port between the CPU
// memory stage (port 0) and the loader/debug master (port 1). One transaction
// is granted per cycle; reads return through a per-port response register one
// cycle after the grant under a valid/ready handshake.
//   req_valid/req_ready/req_we/req_addr/req_wdata  per-port request channel
//   resp_valid/resp_ready/resp_rdata               per-port read response
//   ram_w_addr/ram_wd/ram_we                       RAM write port
//   ram_r_addr/ram_rd                              RAM read port (ram_rd comb)
module ram_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = ram_arb_pkg::NUM_REQ
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [NUM_REQ*DATA_WIDTH-1:0] resp_rdata,
    output logic [DATA_WIDTH-1:0]         ram_w_addr,
    output logic [DATA_WIDTH-1:0]         ram_wd,
    output logic                          ram_we,
    output logic [DATA_WIDTH-1:0]         ram_r_addr,
    input  logic [DATA_WIDTH-1:0]         ram_rd
);

    import ram_arb_pkg::*;

    if (NUM_REQ != 2) begin : g_bad_num_req
        $error("ram_port_arbiter: NUM_REQ must be 2");
    end
    if (DATA_WIDTH != REQ_DATA_W) begin : g_bad_data_width
        $error("ram_port_arbiter: DATA_WIDTH must match ram_arb_pkg::REQ_DATA_W");
    end

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rd_gnt;
    req_t               req [NUM_REQ];
    req_t               sel;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
        resp_state_t           state;
        logic [DATA_WIDTH-1:0] rdata;

        assign req[i] = '{
            we:    req_we[i],
            addr:  req_addr[i*DATA_WIDTH +: DATA_WIDTH],
            wdata: req_wdata[i*DATA_WIDTH +: DATA_WIDTH]
        };

        // Writes never need the response slot; reads need it empty or being
        // drained this very cycle. Reset masks everything.
        assign elig[i]   = rst_n & req_valid[i]
                         & (req_we[i] | (state == RESP_EMPTY) | resp_ready[i]);
        assign rd_gnt[i] = gnt[i] & ~req_we[i];

        // Response register: a granted read always (re)loads it, otherwise a
        // consumed response empties it.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state <= RESP_EMPTY;
                rdata <= '0;
            end else if (rd_gnt[i]) begin
                state <= RESP_FULL;
                rdata <= ram_rd;
            end else if (state == RESP_FULL && resp_ready[i]) begin
                state <= RESP_EMPTY;
            end
        end

        assign resp_valid[i]                          = (state == RESP_FULL);
        assign resp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
    end

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .elig  (elig),
        .gnt   (gnt)
    );

    assign req_ready = gnt;
    assign sel       = gnt[1] ? req[1] : req[0];

    // RAM port drive; all-zero when idle so the RAM sees no stray addresses.
    always_comb begin
        ram_we     = 1'b0;
        ram_w_addr = '0;
        ram_wd     = '0;
        ram_r_addr = '0;
        if (|gnt) begin
            if (sel.we) begin
                ram_we     = 1'b1;
                ram_w_addr = sel.addr;
                ram_wd     = sel.wdata;
            end else begin
                ram_r_addr = sel.addr;
            end
        end
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single read port and single write port of the data RAM between two requesters: port 0 is the CPU memory stage and port 1 is the loader/debug master.
- Grants one transaction per cycle, with round-robin priority across the two ports.
- Read data is captured into a per-port response register and returned one cycle later under a valid/ready handshake.
- Sits between the memory-stage/loader logic and the RAM; it is the only master on the RAM ports.

Parameters:
- DATA_WIDTH, 32, width of address, write data and read data.
- NUM_REQ, 2, number of requesters; fixed at 2, with an elaboration check for any other value.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  NUM_REQ  per-port request valid.
- req_ready  out  NUM_REQ  per-port request accepted this cycle.
- req_we  in  NUM_REQ  per-port request type: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*DATA_WIDTH  per-port word address, port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  per-port write data, same packing.
- resp_valid  out  NUM_REQ  per-port read response valid.
- resp_ready  in  NUM_REQ  per-port response consumed.
- resp_rdata  out  NUM_REQ*DATA_WIDTH  per-port read data.
- ram_w_addr  out  DATA_WIDTH  RAM write address.
- ram_wd  out  DATA_WIDTH  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_r_addr  out  DATA_WIDTH  RAM read address.
- ram_rd  in  DATA_WIDTH  RAM read data, combinational from ram_r_addr.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - resp_valid=0.
  - resp_rdata=0.
  - Priority pointer = port 0.
  - No outstanding reads.
  - Reset wins over any simultaneous request or handshake.
- While rst_n=0 the combinational outputs are also forced: req_ready=0, ram_we=0, ram_w_addr=0, ram_wd=0, ram_r_addr=0.
- Eligibility:
  - A port is eligible when req_valid=1 and it is either a write, or a read with that port's response slot free.
  - A slot is free when resp_valid=0, or resp_valid=1 and resp_ready=1 in the same cycle (pass-through).
- Grant:
  - Combinational, at most one port per cycle.
  - If both ports are eligible, the grant goes to the port the priority pointer names.
  - Otherwise it goes to the single eligible port.
  - req_ready is 1 only for the granted port.
- Pointer update: on any grant, the pointer moves to the other port. If nothing is granted, the pointer holds.
- Granted write:
  - ram_we=1, ram_w_addr=req_addr, ram_wd=req_wdata in the same cycle.
  - The RAM commits it at the edge.
  - No response is generated.
- Granted read:
  - ram_r_addr=req_addr.
  - At the edge, ram_rd is loaded into that port's resp_rdata and resp_valid is set.
  - Latency: request accepted in cycle N, response visible in cycle N+1.
- Idle outputs: when there is no grant, ram_we=0 and ram_r_addr/ram_w_addr/ram_wd hold 0.
- Response register per port, two states: EMPTY and FULL.
  - EMPTY -> FULL on a granted read.
  - FULL -> EMPTY on resp_ready with no new grant.
  - FULL -> FULL (data replaced) on resp_ready together with a granted read.
  - resp_rdata is stable while resp_valid=1 and resp_ready=0.
- Back-pressure: a port holding an unconsumed response has its reads blocked, but its writes remain grantable.
- Ordering:
  - Each port's transactions complete in issue order.
  - A read that follows a write to the same address, granted in a later cycle, returns the new data; the RAM commits writes at the edge.
  - Only one grant per cycle, so a same-cycle read/write hazard between ports cannot occur.
- Fairness: with both ports continuously eligible, grants alternate 0,1,0,1 from reset.

Decomposition:
- Package ram_arb_pkg:
  - Typedef req_t {we, addr, wdata}.
  - Constant NUM_REQ=2.
  - localparam PTR_W.
- One sub-module: rr_arbiter2. It holds the priority pointer and does the grant logic, with inputs elig[1:0] and outputs gnt[1:0] (one-hot or zero). It is reusable for the instruction/data arbitration later.

Test Plan:
- Reset mid-traffic: assert rst_n=0 while port 0 holds resp_valid=1 -> next cycle resp_valid=00, resp_rdata=0, pointer=0, ram_we=0.
- Single read: RAM[0x10004]=0xDEADBEEF; port 0 reads 0x10004 in cycle N -> req_ready[0]=1 in cycle N; resp_valid[0]=1 and resp_rdata=0xDEADBEEF in cycle N+1.
- Write then read:
  - Port 1 writes 0x10008 <= 0x12345678 in cycle N -> ram_we=1, ram_w_addr=0x10008 in cycle N.
  - Port 1 reads 0x10008 in cycle N+1 -> 0x12345678 in cycle N+2.
- Contention: both ports hold a read continuously with resp_ready=1 -> grants 0,1,0,1…; each response appears the cycle after its grant.
- Back-pressure:
  - Port 0 has resp_valid=1 with resp_ready=0; port 0 issues a read -> req_ready[0]=0 and port 1 is granted every cycle.
  - Release resp_ready[0] -> port 0 is granted in that same cycle (pass-through), with the new data the next cycle.
- Write during blocked response: port 0 has a response pending and issues a write to 0x1000C -> the write is granted and ram_we=1; resp_rdata[0] is unchanged.
